// File: rtl/lot_display_pkg.sv
// Shared constants for the lot occupancy display: active-low segment
// patterns {g,f,e,d,c,b,a}, decimal digit decoder and converter states.
package lot_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_R   = 7'b0101111;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_U   = 7'b1000001;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_DONE
  } conv_state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lot_occupancy_display_bin2bcd.sv
// Sequential shift-add-3 binary to 3-digit BCD converter.
// Ports: clk, reset, start/bin in; busy, done, src (captured value), bcd out.
module bin2bcd_seq
  import lot_display_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] src,
  output logic [11:0]  bcd
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  conv_state_e   state_q, state_d;
  logic [W-1:0]  src_q, src_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [11:0]   adj;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      CV_IDLE: begin
        if (start) begin
          src_d   = bin;
          sh_d    = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        bcd_d = {adj[10:0], sh_q[W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = CV_DONE;
      end
      CV_DONE: begin
        done    = 1'b1;
        state_d = CV_IDLE;
      end
      default: state_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CV_IDLE;
      src_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != CV_IDLE);
  assign src  = src_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/lot_occupancy_display.sv
// Saturating lot occupancy counter driving six active-low HEX digits.
// Ports: clk, reset, inc, dec in; count, full, empty, disp_valid, HEX0..HEX5 out.
module lot_occupancy_display
  import lot_display_pkg::*;
#(
  parameter int CAPACITY     = 25,
  parameter int BLINK_CYCLES = 25_000_000,
  localparam int W = $clog2(CAPACITY + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         disp_valid,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX5
);

  localparam logic [W-1:0] CAP = W'(CAPACITY);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [W-1:0]    count_q, count_d;
  logic            start, busy, done;
  logic [W-1:0]    src;
  logic [11:0]     bcd;
  logic [5:0][6:0] hex_q, hex_d;
  logic            show_full_q, show_full_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [6:0]      h0, h1, h2;
  logic            blank;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CAP)
      count_d = count_q + 1'b1;
    else if (dec && !inc && count_q != '0)
      count_d = count_q - 1'b1;
  end

  // Reconvert whenever the live count drifts from the shown value
  assign start = (count_q != src);

  bin2bcd_seq #(
    .W(W)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (count_q),
    .busy  (busy),
    .done  (done),
    .src   (src),
    .bcd   (bcd)
  );

  // Leading-zero blanking for the numeric view
  always_comb begin
    h0 = digit_to_seg(bcd[3:0]);
    h1 = (bcd[11:4] == '0) ? SEG_OFF
                           : digit_to_seg(bcd[7:4]);
    h2 = (bcd[11:8] == '0) ? SEG_OFF
                           : digit_to_seg(bcd[11:8]);
  end

  always_comb begin
    hex_d       = hex_q;
    show_full_d = show_full_q;
    phase_d     = phase_q;
    blink_d     = blink_q;
    if (done) begin
      phase_d     = 1'b1;
      blink_d     = '0;
      show_full_d = (src == CAP);
      unique case (1'b1)
        (src == CAP):
          hex_d = {SEG_F, SEG_U, SEG_L, SEG_L,
                   SEG_OFF, SEG_OFF};
        (src == '0):
          hex_d = {SEG_C, SEG_L, SEG_E, SEG_A,
                   SEG_R, digit_to_seg(4'd0)};
        default:
          hex_d = {SEG_OFF, SEG_OFF, SEG_OFF,
                   h2, h1, h0};
      endcase
    end else if (show_full_q) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = !phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      hex_q       <= {SEG_C, SEG_L, SEG_E, SEG_A,
                      SEG_R, digit_to_seg(4'd0)};
      show_full_q <= 1'b0;
      phase_q     <= 1'b1;
      blink_q     <= '0;
    end else begin
      count_q     <= count_d;
      hex_q       <= hex_d;
      show_full_q <= show_full_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
    end
  end

  assign blank      = show_full_q && !phase_q;
  assign HEX0       = blank ? SEG_OFF : hex_q[0];
  assign HEX1       = blank ? SEG_OFF : hex_q[1];
  assign HEX2       = blank ? SEG_OFF : hex_q[2];
  assign HEX3       = blank ? SEG_OFF : hex_q[3];
  assign HEX4       = blank ? SEG_OFF : hex_q[4];
  assign HEX5       = blank ? SEG_OFF : hex_q[5];
  assign count      = count_q;
  assign full       = (count_q == CAP);
  assign empty      = (count_q == '0);
  assign disp_valid = !busy;

endmodule

// File: tb/tb_lot_occupancy_display.sv
// Self-checking bench for lot_occupancy_display (CAPACITY=25, BLINK_CYCLES=4).
// Ports: none; drives clk/reset/inc/dec and checks count, flags and HEX digits.
module tb_lot_occupancy_display;

  localparam int CAP   = 25;
  localparam int BLINK = 4;
  localparam int W     = 5;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] S_C = 7'b1000110;
  localparam logic [6:0] S_L = 7'b1000111;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_R = 7'b0101111;
  localparam logic [6:0] S_F = 7'b0001110;
  localparam logic [6:0] S_U = 7'b1000001;
  localparam logic [6:0] D0  = 7'b1000000;
  localparam logic [6:0] D1  = 7'b1111001;
  localparam logic [6:0] D2  = 7'b0100100;
  localparam logic [6:0] D4  = 7'b0011001;

  localparam logic [41:0] CLEAR0 = {S_C, S_L, S_E, S_A, S_R, D0};
  localparam logic [41:0] ALLOFF = {6{OFF}};

  logic [6:0] dig_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inc = 1'b0;
  logic         dec = 1'b0;
  logic [W-1:0] count;
  logic         full, empty, disp_valid;
  logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0]  hex_all;

  lot_occupancy_display #(
    .CAPACITY     (CAP),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inc        (inc),
    .dec        (dec),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .disp_valid (disp_valid),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       i;
    logic       d;
    int         cnt;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  vec_t vecs [7];

  // Expected steady display for a settled occupancy value (FULL in phase 1)
  function automatic logic [41:0] exp_disp(input int v);
    logic [6:0] h [6];
    for (int k = 0; k < 6; k++) h[k] = OFF;
    if (v == 0) begin
      return CLEAR0;
    end else if (v == CAP) begin
      return {S_F, S_U, S_L, S_L, OFF, OFF};
    end
    h[0] = dig_tab[v % 10];
    if (v >= 10)  h[1] = dig_tab[(v / 10) % 10];
    if (v >= 100) h[2] = dig_tab[v / 100];
    return {h[5], h[4], h[3], h[2], h[1], h[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic i, input logic d);
    inc = i;
    dec = d;
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   m;
    int   load_edge;
    int   t;
    bit   a, b;
    bit   dropped;
    bit   ok;
    logic [41:0] ref_hex;

    vecs[0] = '{1'b1, 1'b0, 1, OFF, D1};
    vecs[1] = '{1'b1, 1'b0, 2, OFF, D2};
    vecs[2] = '{1'b1, 1'b1, 2, OFF, D2};
    vecs[3] = '{1'b0, 1'b1, 1, OFF, D1};
    vecs[4] = '{1'b0, 1'b1, 0, S_R, D0};
    vecs[5] = '{1'b0, 1'b1, 0, S_R, D0};
    vecs[6] = '{1'b1, 1'b0, 1, OFF, D1};

    @(negedge clk);
    do_reset();

    // Reset state
    tick(10);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst valid", disp_valid, 1);
    chk("rst hex", hex_all, CLEAR0);

    // Exact conversion latency from an idle converter
    pulse(1'b1, 1'b0);
    chk("lat count", count, 1);
    chk("lat valid0", disp_valid, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat low%0d", k), disp_valid, 0);
    end
    chk("lat hex0 old", HEX0, D0);
    @(negedge clk);
    chk("lat hex0 new", HEX0, D1);
    chk("lat hex upper", {HEX5, HEX4, HEX3, HEX2, HEX1}, {5{OFF}});
    chk("lat valid1", disp_valid, 1);

    // Table vectors from empty
    do_reset();
    for (int k = 0; k < 7; k++) begin
      pulse(vecs[k].i, vecs[k].d);
      chk($sformatf("vec%0d count", k), count, vecs[k].cnt);
      tick(20);
      chk($sformatf("vec%0d hex", k), {HEX1, HEX0},
          {vecs[k].h1, vecs[k].h0});
      chk($sformatf("vec%0d valid", k), disp_valid, 1);
    end

    // Fill to capacity, overflow attempts, blink timing
    do_reset();
    load_edge = 0;
    for (int k = 0; k < CAP; k++) begin
      pulse(1'b1, 1'b0);
      if (k == CAP - 1) load_edge = cyc + W + 2;
      tick(9);
    end
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      tick(9);
    end
    chk("full count", count, CAP);
    chk("full flag", full, 1);
    chk("full valid", disp_valid, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      t = cyc - load_edge;
      ref_hex = ((t / BLINK) % 2 == 0) ? exp_disp(CAP) : ALLOFF;
      chk($sformatf("blink t=%0d", t), hex_all, ref_hex);
    end

    // Leave FULL: steady 24
    pulse(1'b0, 1'b1);
    chk("dec count", count, 24);
    chk("dec full", full, 0);
    tick(20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("steady 24", hex_all, {{4{OFF}}, D2, D4});
    end

    // Down to 12, then simultaneous inc/dec
    for (int k = 0; k < 12; k++) begin
      pulse(1'b0, 1'b1);
      tick(1);
    end
    tick(20);
    chk("at 12 count", count, 12);
    chk("at 12 hex", hex_all, exp_disp(12));
    pulse(1'b1, 1'b1);
    chk("both count", count, 12);
    dropped = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (disp_valid !== 1'b1) dropped = 1'b1;
    end
    chk("both no drop", dropped, 0);

    // Underflow attempts at empty
    do_reset();
    dropped = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1);
      if (disp_valid !== 1'b1) dropped = 1'b1;
      tick(3);
    end
    chk("uflow count", count, 0);
    chk("uflow empty", empty, 1);
    chk("uflow no drop", dropped, 0);
    chk("uflow hex", hex_all, CLEAR0);

    // Back-to-back incs from 9 with reconversion
    do_reset();
    for (int k = 0; k < 9; k++) begin
      pulse(1'b1, 1'b0);
      tick(1);
    end
    tick(20);
    chk("at 9 hex", hex_all, exp_disp(9));
    inc = 1'b1;
    tick(3);
    inc = 1'b0;
    chk("b2b count", count, 12);
    tick(25);
    chk("b2b valid", disp_valid, 1);
    chk("b2b hex", {HEX1, HEX0}, {D1, D2});
    chk("b2b hex all", hex_all, exp_disp(12));

    // Asynchronous reset while shifting
    do_reset();
    pulse(1'b1, 1'b0);
    tick(3);
    chk("mid busy", disp_valid, 0);
    reset = 1'b1;
    #1;
    chk("arst count", count, 0);
    chk("arst valid", disp_valid, 1);
    chk("arst hex", hex_all, CLEAR0);
    @(negedge clk);
    reset = 1'b0;
    tick(20);
    chk("arst settle hex", hex_all, CLEAR0);
    chk("arst settle valid", disp_valid, 1);

    // Randomised traffic against a saturating-count model
    do_reset();
    m = 0;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 40; k++) begin
        a = ($urandom_range(0, 9) < ((r % 2 == 0) ? 6 : 3));
        b = ($urandom_range(0, 9) < ((r % 2 == 0) ? 3 : 6));
        inc = a;
        dec = b;
        if (a && !b && m < CAP) m = m + 1;
        else if (b && !a && m > 0) m = m - 1;
        @(negedge clk);
        chk("rand count", count, m);
        chk("rand flags", {full, empty}, {m == CAP, m == 0});
      end
      inc = 1'b0;
      dec = 1'b0;
      tick(20);
      chk("rand valid", disp_valid, 1);
      if (m == CAP) begin
        ok = (hex_all == exp_disp(CAP)) || (hex_all == ALLOFF);
        chk("rand full disp", ok, 1);
      end else begin
        chk($sformatf("rand disp %0d", m), hex_all, exp_disp(m));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_display.md
Name: lot_occupancy_display

Overview:
Parametrised parking-lot occupancy counter with a sequenced 7-segment front end for six active-low HEX digits. It counts single-cycle enter/exit pulses, saturating between 0 and CAPACITY, and converts the count to decimal with a multi-cycle shift-add-3 converter. It shows "CLEAr0" when empty, a blank-padded decimal number when partially full, and a blinking "FULL" when at capacity. It sits between the gate sensor FSMs and the board HEX outputs.

Parameters:
CAPACITY, 25, lot size; legal range 1..999
W, $clog2(CAPACITY+1), count width (derived; not overridden)
BLINK_CYCLES, 25_000_000, clock cycles per FULL blink half-period; must be at least 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
inc  input  1  car-entered pulse, one cycle wide
dec  input  1  car-exited pulse, one cycle wide
count  output  W  live occupancy
full  output  1  count == CAPACITY (combinational from count)
empty  output  1  count == 0 (combinational from count)
disp_valid  output  1  HEX outputs reflect current count
HEX0..HEX5  output  7 each  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: count=0, disp_valid=1, converter IDLE, blink phase=1, blink counter=0, HEX5..HEX0 = C,L,E,A,r,0.
- Counter:
  - inc&!dec: increment, saturating at CAPACITY.
  - dec&!inc: decrement, saturating at 0.
  - inc&dec in the same cycle: no change.
  - A saturated request is dropped silently.
- Converter FSM (states IDLE, SHIFT, DONE):
  - IDLE: if count != src (last converted value), capture src<=count, clear the BCD register, then go to SHIFT.
  - SHIFT: W cycles of add-3-then-shift on the 12-bit BCD register (3 digits), then go to DONE.
  - DONE: load display registers from BCD and src, then return to IDLE.
  - disp_valid=0 from the capture edge until the DONE edge, inclusive of the load.
- Latency: with the converter idle, HEX outputs update exactly W+2 cycles after the edge that sampled the inc/dec pulse.
- Mid-conversion changes: a count change during SHIFT or DONE does not abort the conversion. IDLE sees the mismatch on the next cycle and reconverts. The final display always equals the final count.
- Display selection, based on src and not the live count:
  - src==0: CLEAr0.
  - src==CAPACITY: HEX5..HEX2 = F,U,L,L and HEX1..HEX0 off, gated by blink phase. All six digits are off when phase=0.
  - Otherwise: HEX0=ones, HEX1=tens, HEX2=hundreds, with leading zeros blanked; HEX3..HEX5 off.
  - CAPACITY==1 means values 0 and 1 only; the FULL display takes precedence over numeric for 1.
- Blink:
  - The counter runs only while the displayed state is FULL.
  - Each half-period is BLINK_CYCLES cycles; the phase toggles on each wrap.
  - Entering FULL (on the DONE load) forces phase=1 and counter=0.
  - Leaving FULL resets both.
- reset asserted mid-conversion: immediate return to reset values; no partial display.

Decomposition:
- Package lot_display_pkg holds:
  - Segment constants: SEG_OFF 1111111, C 1000110, L 1000111, E 0000110, A 0001000, r 0101111, F 0001110, U 1000001.
  - Digit table 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Function digit_to_seg.
  - Converter state enum.
- One sub-module, bin2bcd_seq: start/busy/done handshake, W-bit in, 12-bit BCD out. The top holds the counter, blink logic and display registers.

Test Plan (CAPACITY=25, BLINK_CYCLES=4, W=5):
1. Reset, then idle 10 cycles -> count=0, empty=1, disp_valid=1, HEX5..0 = 1000110, 1000111, 0000110, 0001000, 0101111, 1000000.
2. One inc pulse -> count=1 next edge; disp_valid low for 6 cycles; HEX0=1111001 and HEX1..5=1111111 exactly 7 cycles after the pulse edge.
3. 25 inc pulses spaced 10 cycles, then 3 more -> count holds 25, full=1; HEX5..2 = F,U,L,L; HEX5..0 alternate with all-off every 4 cycles.
4. From 25, one dec -> count=24, blinking stops; HEX1=0100100, HEX0=0011001 steady.
5. inc and dec asserted together at count=12 -> count stays 12, no disp_valid drop. Separately, at count=0, three dec pulses -> count stays 0, display stays CLEAr0.
6. Back-to-back inc pulses on 3 consecutive cycles from 9, plus reset asserted mid-SHIFT in a second run -> first run settles to 12 (HEX1=1111001, HEX0=0100100) with disp_valid=1; the reset run shows reset values immediately.
